request_block_2ch_bridge: RTL and testbench
===========================================

# request_block_2ch_bridge

Single-slave request arbiter and response-valid decoder for the bridge crossbar. It merges two groups of masters, CH0 (N_CH0 ports) and CH1 (N_CH1 ports), onto one memory-side request port, returning grants to the winners. It routes each memory response valid back to the originating master using the one-hot ID. One instance sits in front of each slave of the crossbar.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- N_CH0, 5, number of CH0 masters (≥1)
- N_CH1, 4, number of CH1 masters (≥1)
- ID_WIDTH, N_CH0+N_CH1, one-hot master ID width
- AUX_WIDTH, 8, sideband width
- DATA_WIDTH, 32, write data width
- BE_WIDTH, DATA_WIDTH/8, byte-enable width

Ports (one clock; reset is synchronous and active-low, clk / rst_n):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- data_req_CH0_i / data_req_CH1_i  in  N_CH0 / N_CH1  per-master request
- data_add_CH{0,1}_i  in  N×ADDR_WIDTH  address
- data_wen_CH{0,1}_i  in  N  1=load, 0=store
- data_wdata_CH{0,1}_i  in  N×DATA_WIDTH  write data
- data_be_CH{0,1}_i  in  N×BE_WIDTH  byte enables
- data_ID_CH{0,1}_i  in  N×ID_WIDTH  master one-hot ID
- data_aux_CH{0,1}_i  in  N×AUX_WIDTH  sideband
- data_gnt_CH0_o / data_gnt_CH1_o  out  N_CH0 / N_CH1  per-master grant
- data_req_o, data_wen_o  out  1  memory request / type
- data_add_o, data_wdata_o, data_be_o, data_ID_o, data_aux_o  out  matching widths  winner's fields
- data_gnt_i  in  1  memory grant
- data_r_valid_i  in  1  memory response valid
- data_r_ID_i  in  ID_WIDTH  response ID
- data_r_valid_CH0_o / data_r_valid_CH1_o  out  N_CH0 / N_CH1  per-master response valid

## Operation
- data_req_o = OR of all master requests.
- Per-channel round-robin: pointer p_CH (0..N−1). Winner is the first requesting index scanning p_CH, p_CH+1, … with wrap.
- Channel select (no macro): when only one channel requests, it wins. When both request, the channel flag picks the winner (reset value: CH0).
- Winner's add/wen/wdata/be/ID/aux drive the memory outputs. All request-side outputs are 0 when no master requests.
- Grant: data_gnt_CHx_o[k] = data_gnt_i & (k is the overall winner). All other grants are 0. A master is never granted without its request.
- Response: data_r_valid_CH0_o[k] = data_r_valid_i & data_r_ID_i[k]; data_r_valid_CH1_o[k] = data_r_valid_i & data_r_ID_i[N_CH0+k].
- Response path is purely combinational and independent of arbitration state.
- State update on each accepted transfer (data_req_o & data_gnt_i):
  - the winning channel's pointer becomes (winner+1) mod N;
  - the channel flag becomes the other channel.
  - No state change without a transfer.
- A request held while not granted keeps its fields stable; the arbiter does not enforce this.

## Timing
- All outputs are combinational from inputs and state: zero-cycle request/grant and response-valid paths.
- State registers (p_CH0, p_CH1, flag) update on rising clk.
- rst_n low at a clock edge sets p_CH0 = p_CH1 = 0 and flag = CH0. This applies even mid-transfer; an in-flight grant in that cycle is still output combinationally.
- Reset values of outputs follow from inputs. With all requests low, every output is 0 except the response valids, which follow data_r_valid_i/data_r_ID_i.
- Simultaneous response valid and new request are independent.

## Configuration
- CH0_STRICT_PRIORITY_EN defined: CH0 always wins over CH1 when any CH0 master requests. The channel flag is not implemented. Round-robin within each channel is unchanged.
- Undefined: alternating channel flag as described in Operation.

## Test plan
Use N_CH0=2, N_CH1=2.
- Reset, then CH0[0] requests with add=0x10, gnt_i=1 → data_req_o=1, data_add_o=0x10, data_gnt_CH0_o=01, p_CH0→1.
- CH0[0] and CH0[1] request continuously, gnt_i=1 → grants alternate 01,10,01 on successive cycles.
- CH0[0] and CH1[1] request, gnt_i=1 for 3 cycles, macro off → winners CH0[0], CH1[1], CH0[0]. Macro on → CH0[0] every cycle.
- gnt_i=0 with requests held → all grants 0, pointers and flag unchanged, outputs stable.
- data_r_valid_i=1 with data_r_ID_i=4'b0100 → data_r_valid_CH1_o=01 and data_r_valid_CH0_o=00. With data_r_valid_i=0 → all valids 0.
- rst_n low while pointers are nonzero → next cycle, CH0[0]/CH0[1] contention grants CH0[0] first.

Source files
------------

// File: rtl/request_block_2ch_bridge_if.sv
// ---------------------------------------------------------------------------
// request_block_2ch_bridge_if
// Bundle of the bridge's master-side (CH0/CH1) and memory-side signals.
// Suffixes are relative to the bridge: _i are bridge inputs, _o bridge outputs.
//   slave  modport : used by the bridge itself
//   master modport : used by whatever drives the bridge (masters + memory)
// Per-master fields are packed arrays indexed by master number.
// ---------------------------------------------------------------------------
interface request_block_2ch_bridge_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int N_CH0      = 5,
   parameter int N_CH1      = 4,
   parameter int ID_WIDTH   = N_CH0 + N_CH1,
   parameter int AUX_WIDTH  = 8,
   parameter int DATA_WIDTH = 32,
   parameter int BE_WIDTH   = DATA_WIDTH / 8
);
   // CH0 masters
   logic [N_CH0-1:0]                 data_req_CH0_i;
   logic [N_CH0-1:0][ADDR_WIDTH-1:0] data_add_CH0_i;
   logic [N_CH0-1:0]                 data_wen_CH0_i;
   logic [N_CH0-1:0][DATA_WIDTH-1:0] data_wdata_CH0_i;
   logic [N_CH0-1:0][BE_WIDTH-1:0]   data_be_CH0_i;
   logic [N_CH0-1:0][ID_WIDTH-1:0]   data_ID_CH0_i;
   logic [N_CH0-1:0][AUX_WIDTH-1:0]  data_aux_CH0_i;
   logic [N_CH0-1:0]                 data_gnt_CH0_o;
   logic [N_CH0-1:0]                 data_r_valid_CH0_o;
   // CH1 masters
   logic [N_CH1-1:0]                 data_req_CH1_i;
   logic [N_CH1-1:0][ADDR_WIDTH-1:0] data_add_CH1_i;
   logic [N_CH1-1:0]                 data_wen_CH1_i;
   logic [N_CH1-1:0][DATA_WIDTH-1:0] data_wdata_CH1_i;
   logic [N_CH1-1:0][BE_WIDTH-1:0]   data_be_CH1_i;
   logic [N_CH1-1:0][ID_WIDTH-1:0]   data_ID_CH1_i;
   logic [N_CH1-1:0][AUX_WIDTH-1:0]  data_aux_CH1_i;
   logic [N_CH1-1:0]                 data_gnt_CH1_o;
   logic [N_CH1-1:0]                 data_r_valid_CH1_o;
   // memory side
   logic                             data_req_o;
   logic [ADDR_WIDTH-1:0]            data_add_o;
   logic                             data_wen_o;
   logic [DATA_WIDTH-1:0]            data_wdata_o;
   logic [BE_WIDTH-1:0]              data_be_o;
   logic [ID_WIDTH-1:0]              data_ID_o;
   logic [AUX_WIDTH-1:0]             data_aux_o;
   logic                             data_gnt_i;
   logic                             data_r_valid_i;
   logic [ID_WIDTH-1:0]              data_r_ID_i;

   modport slave (
      input  data_req_CH0_i, data_add_CH0_i, data_wen_CH0_i, data_wdata_CH0_i,
             data_be_CH0_i, data_ID_CH0_i, data_aux_CH0_i,
             data_req_CH1_i, data_add_CH1_i, data_wen_CH1_i, data_wdata_CH1_i,
             data_be_CH1_i, data_ID_CH1_i, data_aux_CH1_i,
             data_gnt_i, data_r_valid_i, data_r_ID_i,
      output data_gnt_CH0_o, data_gnt_CH1_o, data_r_valid_CH0_o, data_r_valid_CH1_o,
             data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o,
             data_ID_o, data_aux_o
   );

   modport master (
      output data_req_CH0_i, data_add_CH0_i, data_wen_CH0_i, data_wdata_CH0_i,
             data_be_CH0_i, data_ID_CH0_i, data_aux_CH0_i,
             data_req_CH1_i, data_add_CH1_i, data_wen_CH1_i, data_wdata_CH1_i,
             data_be_CH1_i, data_ID_CH1_i, data_aux_CH1_i,
             data_gnt_i, data_r_valid_i, data_r_ID_i,
      input  data_gnt_CH0_o, data_gnt_CH1_o, data_r_valid_CH0_o, data_r_valid_CH1_o,
             data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o,
             data_ID_o, data_aux_o
   );
endinterface

// File: rtl/request_block_2ch_bridge.sv
// ---------------------------------------------------------------------------
// request_block_2ch_bridge
// Merges two groups of masters (CH0, CH1) onto one memory request port.
// Round-robin within each channel; between channels an alternating turn flag
// decides when both channels request. Memory response valids are decoded
// back to masters from the one-hot response ID.
//
// Ports:
//   clk    - clock
//   rst_n  - synchronous active-low reset (pointers -> 0, turn -> CH0)
//   bus    - request_block_2ch_bridge_if.slave: per-master request/grant/
//            response-valid vectors and the memory-side request port
//
// Build option:
//   CH0_STRICT_PRIORITY_EN - CH0 always beats CH1; no turn flag exists.
//
// All outputs are combinational from inputs and state (zero-cycle paths).
// ---------------------------------------------------------------------------
module request_block_2ch_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int N_CH0      = 5,
   parameter int N_CH1      = 4,
   parameter int ID_WIDTH   = N_CH0 + N_CH1,
   parameter int AUX_WIDTH  = 8,
   parameter int DATA_WIDTH = 32,
   parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
   input logic                      clk,
   input logic                      rst_n,
   request_block_2ch_bridge_if.slave bus
);

   localparam int PW0 = (N_CH0 > 1) ? $clog2(N_CH0) : 1;
   localparam int PW1 = (N_CH1 > 1) ? $clog2(N_CH1) : 1;

   typedef enum logic {TURN_CH0 = 1'b0, TURN_CH1 = 1'b1} turn_e;

   logic [PW0-1:0] ptr0_q, ptr0_d, win0, nxt0;
   logic [PW1-1:0] ptr1_q, ptr1_d, win1, nxt1;
   logic           any0, any1, sel1, xfer;
   int             best0, best1, dist0, dist1;

   // Round-robin pick: among requesting masters, the one at the smallest
   // forward distance from the pointer wins.
   always_comb begin
      any0  = |bus.data_req_CH0_i;
      win0  = '0;
      best0 = N_CH0;
      dist0 = 0;
      for (int k = 0; k < N_CH0; k++) begin
         dist0 = (k >= int'(ptr0_q)) ? k - int'(ptr0_q) : k + N_CH0 - int'(ptr0_q);
         if (bus.data_req_CH0_i[k] && dist0 < best0) begin
            best0 = dist0;
            win0  = PW0'(k);
         end
      end
      nxt0 = (int'(win0) == N_CH0 - 1) ? '0 : win0 + 1'b1;
   end

   always_comb begin
      any1  = |bus.data_req_CH1_i;
      win1  = '0;
      best1 = N_CH1;
      dist1 = 0;
      for (int k = 0; k < N_CH1; k++) begin
         dist1 = (k >= int'(ptr1_q)) ? k - int'(ptr1_q) : k + N_CH1 - int'(ptr1_q);
         if (bus.data_req_CH1_i[k] && dist1 < best1) begin
            best1 = dist1;
            win1  = PW1'(k);
         end
      end
      nxt1 = (int'(win1) == N_CH1 - 1) ? '0 : win1 + 1'b1;
   end

`ifdef CH0_STRICT_PRIORITY_EN
   assign sel1 = any1 & ~any0;
`else
   turn_e flag_q, flag_d;
   // CH1 wins when it is alone or when both request and it is CH1's turn.
   assign sel1 = any1 & (~any0 | (flag_q == TURN_CH1));
`endif

   assign xfer = (any0 | any1) & bus.data_gnt_i;

   // Memory-side mux and grant steering; everything is zero when idle.
   always_comb begin
      bus.data_req_o     = any0 | any1;
      bus.data_add_o     = '0;
      bus.data_wen_o     = 1'b0;
      bus.data_wdata_o   = '0;
      bus.data_be_o      = '0;
      bus.data_ID_o      = '0;
      bus.data_aux_o     = '0;
      bus.data_gnt_CH0_o = '0;
      bus.data_gnt_CH1_o = '0;
      if (sel1) begin
         bus.data_add_o       = bus.data_add_CH1_i[win1];
         bus.data_wen_o       = bus.data_wen_CH1_i[win1];
         bus.data_wdata_o     = bus.data_wdata_CH1_i[win1];
         bus.data_be_o        = bus.data_be_CH1_i[win1];
         bus.data_ID_o        = bus.data_ID_CH1_i[win1];
         bus.data_aux_o       = bus.data_aux_CH1_i[win1];
         bus.data_gnt_CH1_o[win1] = bus.data_gnt_i;
      end else if (any0) begin
         bus.data_add_o       = bus.data_add_CH0_i[win0];
         bus.data_wen_o       = bus.data_wen_CH0_i[win0];
         bus.data_wdata_o     = bus.data_wdata_CH0_i[win0];
         bus.data_be_o        = bus.data_be_CH0_i[win0];
         bus.data_ID_o        = bus.data_ID_CH0_i[win0];
         bus.data_aux_o       = bus.data_aux_CH0_i[win0];
         bus.data_gnt_CH0_o[win0] = bus.data_gnt_i;
      end
   end

   // Response decode: bit k of the one-hot ID maps to CH0[k], bit N_CH0+k to CH1[k].
   assign bus.data_r_valid_CH0_o = {N_CH0{bus.data_r_valid_i}} & bus.data_r_ID_i[N_CH0-1:0];
   assign bus.data_r_valid_CH1_o = {N_CH1{bus.data_r_valid_i}} & bus.data_r_ID_i[N_CH0 +: N_CH1];

   // Next state: only the winning channel advances, and the turn passes to
   // the channel that did not win.
   always_comb begin
      ptr0_d = ptr0_q;
      ptr1_d = ptr1_q;
`ifndef CH0_STRICT_PRIORITY_EN
      flag_d = flag_q;
`endif
      if (xfer) begin
         if (sel1) ptr1_d = nxt1;
         else      ptr0_d = nxt0;
`ifndef CH0_STRICT_PRIORITY_EN
         flag_d = sel1 ? TURN_CH0 : TURN_CH1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr0_q <= '0;
         ptr1_q <= '0;
`ifndef CH0_STRICT_PRIORITY_EN
         flag_q <= TURN_CH0;
`endif
      end else begin
         ptr0_q <= ptr0_d;
         ptr1_q <= ptr1_d;
`ifndef CH0_STRICT_PRIORITY_EN
         flag_q <= flag_d;
`endif
      end
   end

endmodule

// File: tb/tb_request_block_2ch_bridge.sv
module tb_request_block_2ch_bridge;
   localparam int AW = 32, N0 = 2, N1 = 2, IW = 4, XW = 8, DW = 32, BW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   request_block_2ch_bridge_if #(.ADDR_WIDTH(AW), .N_CH0(N0), .N_CH1(N1), .ID_WIDTH(IW),
      .AUX_WIDTH(XW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) bus ();

   request_block_2ch_bridge #(.ADDR_WIDTH(AW), .N_CH0(N0), .N_CH1(N1), .ID_WIDTH(IW),
      .AUX_WIDTH(XW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // reference state: round-robin pointers and whose turn it is (0=CH0, 1=CH1)
   int mp0, mp1, mturn;

   // Walk masters in order starting at the pointer; first requester wins.
   function automatic int pick(input logic [1:0] req, input int p, input int n);
      for (int off = 0; off < n; off++) begin
         int k;
         k = (p + off) % n;
         if (req[k]) return k;
      end
      return -1;
   endfunction

   task automatic idle();
      bus.data_req_CH0_i = '0; bus.data_req_CH1_i = '0;
      bus.data_add_CH0_i = '0; bus.data_add_CH1_i = '0;
      bus.data_wen_CH0_i = '0; bus.data_wen_CH1_i = '0;
      bus.data_wdata_CH0_i = '0; bus.data_wdata_CH1_i = '0;
      bus.data_be_CH0_i = '0; bus.data_be_CH1_i = '0;
      bus.data_ID_CH0_i = '0; bus.data_ID_CH1_i = '0;
      bus.data_aux_CH0_i = '0; bus.data_aux_CH1_i = '0;
      bus.data_gnt_i = 1'b0; bus.data_r_valid_i = 1'b0; bus.data_r_ID_i = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      step();
      rst_n = 1'b1;
      mp0 = 0; mp1 = 0; mturn = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      step();
      #2;
      n_cmp++;
      if ({bus.data_req_o, bus.data_wen_o, bus.data_gnt_CH0_o, bus.data_gnt_CH1_o,
           bus.data_r_valid_CH0_o, bus.data_r_valid_CH1_o} !== 10'd0) begin
         n_err++; $display("FAIL reset_ctrl got %b want 0", {bus.data_req_o, bus.data_wen_o,
            bus.data_gnt_CH0_o, bus.data_gnt_CH1_o, bus.data_r_valid_CH0_o, bus.data_r_valid_CH1_o});
      end
      n_cmp++;
      if ({bus.data_add_o, bus.data_wdata_o, bus.data_be_o, bus.data_ID_o, bus.data_aux_o} !== '0) begin
         n_err++; $display("FAIL reset_fields got %h want 0",
            {bus.data_add_o, bus.data_wdata_o, bus.data_be_o, bus.data_ID_o, bus.data_aux_o});
      end
      rst_n = 1'b1;
      mp0 = 0; mp1 = 0; mturn = 0;
   endtask

   task automatic test_single();
      do_reset();
      bus.data_req_CH0_i = 2'b01;
      bus.data_add_CH0_i[0] = 32'h10;
      bus.data_gnt_i = 1'b1;
      #2;
      n_cmp++;
      if (bus.data_req_o !== 1'b1) begin n_err++; $display("FAIL single_req got %b want 1", bus.data_req_o); end
      n_cmp++;
      if (bus.data_add_o !== 32'h10) begin n_err++; $display("FAIL single_add got %h want 10", bus.data_add_o); end
      n_cmp++;
      if (bus.data_gnt_CH0_o !== 2'b01) begin n_err++; $display("FAIL single_gnt got %b want 01", bus.data_gnt_CH0_o); end
      step();
      // pointer now 1: contention goes to CH0[1]
      bus.data_req_CH0_i = 2'b11;
      #2;
      n_cmp++;
      if (bus.data_gnt_CH0_o !== 2'b10) begin n_err++; $display("FAIL single_ptr got %b want 10", bus.data_gnt_CH0_o); end
   endtask

   task automatic test_rr_ch0();
      logic [1:0] exp_g [3];
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
      do_reset();
      bus.data_req_CH0_i = 2'b11;
      bus.data_gnt_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #2;
         n_cmp++;
         if (bus.data_gnt_CH0_o !== exp_g[c]) begin
            n_err++; $display("FAIL rr_ch0 cyc%0d got %b want %b", c, bus.data_gnt_CH0_o, exp_g[c]);
         end
         step();
      end
   endtask

   task automatic test_cross();
      logic [3:0] exp_g [3];   // {gnt_CH1, gnt_CH0}
`ifdef CH0_STRICT_PRIORITY_EN
      exp_g[0] = 4'b0001; exp_g[1] = 4'b0001; exp_g[2] = 4'b0001;
`else
      exp_g[0] = 4'b0001; exp_g[1] = 4'b1000; exp_g[2] = 4'b0001;
`endif
      do_reset();
      bus.data_req_CH0_i = 2'b01;
      bus.data_req_CH1_i = 2'b10;
      bus.data_add_CH0_i[0] = 32'hA0;
      bus.data_add_CH1_i[1] = 32'hB1;
      bus.data_gnt_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #2;
         n_cmp++;
         if ({bus.data_gnt_CH1_o, bus.data_gnt_CH0_o} !== exp_g[c]) begin
            n_err++; $display("FAIL cross cyc%0d got %b want %b", c,
               {bus.data_gnt_CH1_o, bus.data_gnt_CH0_o}, exp_g[c]);
         end
         n_cmp++;
         if (bus.data_add_o !== (exp_g[c][3] ? 32'hB1 : 32'hA0)) begin
            n_err++; $display("FAIL cross_add cyc%0d got %h", c, bus.data_add_o);
         end
         step();
      end
   endtask

   task automatic test_hold();
      logic [31:0] exp_add;
      logic [3:0]  exp_g1, exp_g2;
      do_reset();
      bus.data_req_CH0_i = 2'b11;
      bus.data_req_CH1_i = 2'b01;
      bus.data_add_CH0_i[0] = 32'h100; bus.data_add_CH0_i[1] = 32'h101;
      bus.data_add_CH1_i[0] = 32'h200; bus.data_add_CH1_i[1] = 32'h201;
      bus.data_gnt_i = 1'b1;
      step();   // CH0[0] accepted
`ifdef CH0_STRICT_PRIORITY_EN
      exp_add = 32'h101; exp_g1 = 4'b0010; exp_g2 = 4'b0001;
`else
      exp_add = 32'h200; exp_g1 = 4'b0100; exp_g2 = 4'b0010;
`endif
      bus.data_gnt_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #2;
         n_cmp++;
         if ({bus.data_gnt_CH1_o, bus.data_gnt_CH0_o} !== 4'b0000) begin
            n_err++; $display("FAIL hold_gnt cyc%0d got %b want 0000", c, {bus.data_gnt_CH1_o, bus.data_gnt_CH0_o});
         end
         n_cmp++;
         if (bus.data_req_o !== 1'b1 || bus.data_add_o !== exp_add) begin
            n_err++; $display("FAIL hold_add cyc%0d got %b/%h want 1/%h", c, bus.data_req_o, bus.data_add_o, exp_add);
         end
         step();
      end
      bus.data_gnt_i = 1'b1;
      #2;
      n_cmp++;
      if ({bus.data_gnt_CH1_o, bus.data_gnt_CH0_o} !== exp_g1) begin
         n_err++; $display("FAIL hold_resume got %b want %b", {bus.data_gnt_CH1_o, bus.data_gnt_CH0_o}, exp_g1);
      end
      step();
      #2;
      n_cmp++;
      if ({bus.data_gnt_CH1_o, bus.data_gnt_CH0_o} !== exp_g2) begin
         n_err++; $display("FAIL hold_next got %b want %b", {bus.data_gnt_CH1_o, bus.data_gnt_CH0_o}, exp_g2);
      end
      step();
   endtask

   task automatic test_response();
      do_reset();
      bus.data_req_CH0_i = 2'b01;   // request in parallel must not matter
      bus.data_gnt_i = 1'b1;
      bus.data_r_valid_i = 1'b1;
      bus.data_r_ID_i = 4'b0100;
      #2;
      n_cmp++;
      if ({bus.data_r_valid_CH1_o, bus.data_r_valid_CH0_o} !== 4'b0100) begin
         n_err++; $display("FAIL resp_on got %b want 0100", {bus.data_r_valid_CH1_o, bus.data_r_valid_CH0_o});
      end
      bus.data_r_valid_i = 1'b0;
      #2;
      n_cmp++;
      if ({bus.data_r_valid_CH1_o, bus.data_r_valid_CH0_o} !== 4'b0000) begin
         n_err++; $display("FAIL resp_off got %b want 0000", {bus.data_r_valid_CH1_o, bus.data_r_valid_CH0_o});
      end
      step();
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.data_req_CH0_i = 2'b01;
      bus.data_gnt_i = 1'b1;
      step();                 // pointer CH0 -> 1
      bus.data_req_CH0_i = 2'b11;
      rst_n = 1'b0;
      #2;
      n_cmp++;
      if (bus.data_gnt_CH0_o !== 2'b10) begin
         n_err++; $display("FAIL rstmid_inflight got %b want 10", bus.data_gnt_CH0_o);
      end
      step();
      rst_n = 1'b1;
      #2;
      n_cmp++;
      if (bus.data_gnt_CH0_o !== 2'b01) begin
         n_err++; $display("FAIL rstmid_after got %b want 01", bus.data_gnt_CH0_o);
      end
      step();
   endtask

   task automatic test_random();
      int w0, w1;
      bit any0, any1, ch1, anyr;
      logic [31:0] e_add, e_wdata;
      logic [3:0]  e_be, e_id, e_rv;
      logic [7:0]  e_aux;
      logic        e_wen;
      logic [1:0]  e_g0, e_g1;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rst_n = ($urandom_range(0, 29) != 0);
         bus.data_req_CH0_i = 2'($urandom);
         bus.data_req_CH1_i = 2'($urandom);
         for (int k = 0; k < 2; k++) begin
            bus.data_add_CH0_i[k] = $urandom;    bus.data_add_CH1_i[k] = $urandom;
            bus.data_wdata_CH0_i[k] = $urandom;  bus.data_wdata_CH1_i[k] = $urandom;
            bus.data_be_CH0_i[k] = 4'($urandom); bus.data_be_CH1_i[k] = 4'($urandom);
            bus.data_ID_CH0_i[k] = 4'($urandom); bus.data_ID_CH1_i[k] = 4'($urandom);
            bus.data_aux_CH0_i[k] = 8'($urandom); bus.data_aux_CH1_i[k] = 8'($urandom);
         end
         bus.data_wen_CH0_i = 2'($urandom);
         bus.data_wen_CH1_i = 2'($urandom);
         bus.data_gnt_i = ($urandom_range(0, 3) != 0);
         bus.data_r_valid_i = 1'($urandom);
         bus.data_r_ID_i = 4'($urandom);

         w0 = pick(bus.data_req_CH0_i, mp0, N0);
         w1 = pick(bus.data_req_CH1_i, mp1, N1);
         any0 = (w0 >= 0);
         any1 = (w1 >= 0);
         anyr = any0 || any1;
`ifdef CH0_STRICT_PRIORITY_EN
         ch1 = any1 && !any0;
`else
         ch1 = any1 && (!any0 || mturn == 1);
`endif
         e_add = 0; e_wdata = 0; e_be = 0; e_id = 0; e_aux = 0; e_wen = 0; e_g0 = 0; e_g1 = 0;
         if (ch1) begin
            e_add = bus.data_add_CH1_i[w1]; e_wdata = bus.data_wdata_CH1_i[w1];
            e_be = bus.data_be_CH1_i[w1]; e_id = bus.data_ID_CH1_i[w1];
            e_aux = bus.data_aux_CH1_i[w1]; e_wen = bus.data_wen_CH1_i[w1];
            e_g1[w1] = bus.data_gnt_i;
         end else if (any0) begin
            e_add = bus.data_add_CH0_i[w0]; e_wdata = bus.data_wdata_CH0_i[w0];
            e_be = bus.data_be_CH0_i[w0]; e_id = bus.data_ID_CH0_i[w0];
            e_aux = bus.data_aux_CH0_i[w0]; e_wen = bus.data_wen_CH0_i[w0];
            e_g0[w0] = bus.data_gnt_i;
         end
         e_rv = bus.data_r_valid_i ? bus.data_r_ID_i : 4'b0000;
         #2;
         n_cmp++;
         if (bus.data_req_o !== anyr || bus.data_wen_o !== e_wen) begin
            n_err++; $display("FAIL rnd%0d req/wen got %b%b want %b%b", c, bus.data_req_o, bus.data_wen_o, anyr, e_wen);
         end
         n_cmp++;
         if ({bus.data_add_o, bus.data_wdata_o, bus.data_be_o, bus.data_ID_o, bus.data_aux_o} !==
             {e_add, e_wdata, e_be, e_id, e_aux}) begin
            n_err++; $display("FAIL rnd%0d fields got %h want %h", c,
               {bus.data_add_o, bus.data_wdata_o, bus.data_be_o, bus.data_ID_o, bus.data_aux_o},
               {e_add, e_wdata, e_be, e_id, e_aux});
         end
         n_cmp++;
         if ({bus.data_gnt_CH1_o, bus.data_gnt_CH0_o} !== {e_g1, e_g0}) begin
            n_err++; $display("FAIL rnd%0d gnt got %b want %b", c, {bus.data_gnt_CH1_o, bus.data_gnt_CH0_o}, {e_g1, e_g0});
         end
         n_cmp++;
         if ({bus.data_r_valid_CH1_o, bus.data_r_valid_CH0_o} !== e_rv) begin
            n_err++; $display("FAIL rnd%0d rvalid got %b want %b", c,
               {bus.data_r_valid_CH1_o, bus.data_r_valid_CH0_o}, e_rv);
         end
         // advance the reference at the clock edge
         if (!rst_n) begin
            mp0 = 0; mp1 = 0; mturn = 0;
         end else if (anyr && bus.data_gnt_i) begin
            if (ch1) begin mp1 = (w1 + 1) % N1; mturn = 0; end
            else     begin mp0 = (w0 + 1) % N0; mturn = 1; end
         end
         step();
      end
      rst_n = 1'b1;
   endtask

   initial begin
      idle();
      test_reset();
      test_single();
      test_rr_ch0();
      test_cross();
      test_hold();
      test_response();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
